// File: rtl/jtframe_romrq_slot.sv
// ROM responder with a 2-entry line cache; fetches 32-bit lines from SDRAM on a miss.
// Hit: rom_ok one clock after request; miss: rom_ok 2 clocks after data_rdy. rom_cs held high is the backpressure.
module jtframe_romrq_slot #(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic [AW-1:0] rom_addr,
  input  logic          rom_cs,
  output logic          rom_ok,
  output logic [DW-1:0] rom_data,
  input  logic          flush,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [31:0]   data_read
);

  localparam int LW = (DW == 8) ? 2 : 1;
  localparam int TW = AW - LW;
  localparam int NL = 32 / DW;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    valid_q;
  logic [TW-1:0] tag_q  [2];
  logic [31:0]   line_q [2];
  logic          victim_q;
  logic          discard_q, discard_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          ok_q;
  logic [AW-1:0] ok_addr_q;
  logic [DW-1:0] data_q;

  logic [TW-1:0] cur_tag;
  logic          hit0, hit1, hit;
  logic [31:0]   sel_line;
  logic [DW-1:0] lane;
  logic          fill, fill_we;

  assign cur_tag = rom_addr[AW-1:LW];
  assign hit0    = valid_q[0] && (tag_q[0] == cur_tag);
  assign hit1    = valid_q[1] && (tag_q[1] == cur_tag);
  assign hit     = rom_cs && (hit0 || hit1);
  assign sel_line = hit1 ? line_q[1] : line_q[0];

  always_comb begin
    lane = '0;
    for (int i = 0; i < NL; i++) begin
      if (rom_addr[LW-1:0] == LW'(i)) lane = sel_line[i*DW +: DW];
    end
  end

  // ack and data_rdy together in REQ complete the transaction in one step
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rom_cs && !hit) begin
          state_d    = REQ;
          req_addr_d = {cur_tag, {LW{1'b0}}};
          discard_d  = 1'b0;
        end
      end
      REQ: begin
        if (flush) discard_d = 1'b1;
        if (sdram_ack) begin
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) discard_d = 1'b1;
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a flush anywhere in the transaction, including the fill cycle, drops the line
  assign fill_we = fill && !discard_q && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      victim_q  <= 1'b0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      line_q[0] <= '0;
      line_q[1] <= '0;
    end else if (flush) begin
      valid_q  <= '0;
      victim_q <= 1'b0;
    end else if (fill_we) begin
      valid_q[victim_q] <= 1'b1;
      tag_q[victim_q]   <= req_addr_q[AW-1:LW];
      line_q[victim_q]  <= data_read;
      victim_q          <= ~victim_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q      <= 1'b0;
      ok_addr_q <= '0;
      data_q    <= '0;
    end else begin
      ok_q      <= hit && !flush;
      ok_addr_q <= rom_addr;
      if (hit) data_q <= lane;
    end
  end

  assign rom_ok     = ok_q && rom_cs && (rom_addr == ok_addr_q);
  assign rom_data   = data_q;
  assign sdram_req  = (state_q == REQ);
  assign sdram_addr = req_addr_q;

endmodule

// File: tb/tb_jtframe_romrq_slot.sv
// Directed bench for jtframe_romrq_slot (AW=18, DW=8): miss, hit, replacement, abort, flush, reset.
module tb_jtframe_romrq_slot;

  logic        rst_n, clk;
  logic [17:0] rom_addr;
  logic        rom_cs, rom_ok, flush, sdram_req, sdram_ack, data_rdy;
  logic [7:0]  rom_data;
  logic [17:0] sdram_addr;
  logic [31:0] data_read;

  int tests = 0;
  int fails = 0;

  jtframe_romrq_slot #(.AW(18), .DW(8)) dut (
    .rst_n(rst_n), .clk(clk), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .rom_data(rom_data), .flush(flush), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rom_addr = '0; rom_cs = 1'b0; flush = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    #12;
    check("rst_rom_ok", 32'(rom_ok), 0);
    check("rst_rom_data", 32'(rom_data), 0);
    check("rst_req", 32'(sdram_req), 0);
    check("rst_sdram_addr", 32'(sdram_addr), 0);
    step();
    rst_n = 1'b1;
    step();

    // cold miss
    rom_addr = 18'h00005; rom_cs = 1'b1;
    step();
    check("miss_req", 32'(sdram_req), 1);
    check("miss_addr", 32'(sdram_addr), 32'h4);
    step(); step();
    check("req_held", 32'(sdram_req), 1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("req_drop_on_ack", 32'(sdram_req), 0);
    step(); step(); step();
    check("wait_no_ok", 32'(rom_ok), 0);
    data_rdy = 1'b1; data_read = 32'hDDCCBBAA;
    step();
    data_rdy = 1'b0;
    check("fill_ok_not_yet", 32'(rom_ok), 0);
    step();
    check("fill_ok", 32'(rom_ok), 1);
    check("fill_data", 32'(rom_data), 32'hBB);

    // hit on the resident line
    rom_addr = 18'h00007;
    #1;
    check("hit_addr_chg_ok", 32'(rom_ok), 0);
    step();
    check("hit_ok", 32'(rom_ok), 1);
    check("hit_data", 32'(rom_data), 32'hDD);
    check("hit_no_req", 32'(sdram_req), 0);

    // address change to a miss
    rom_addr = 18'h00100;
    #1;
    check("chg_ok_drop", 32'(rom_ok), 0);
    step();
    check("chg_req", 32'(sdram_req), 1);
    check("chg_addr", 32'(sdram_addr), 32'h100);
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h11223344;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    check("ackrdy_req", 32'(sdram_req), 0);
    step();
    check("ackrdy_ok", 32'(rom_ok), 1);
    check("ackrdy_data", 32'(rom_data), 32'h44);

    // replacement: 0x200 evicts 0x000
    rom_addr = 18'h00200;
    step();
    check("r200_req", 32'(sdram_req), 1);
    check("r200_addr", 32'(sdram_addr), 32'h200);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b1; data_read = 32'h55667788;
    step();
    data_rdy = 1'b0;
    step();
    check("r200_ok", 32'(rom_ok), 1);
    check("r200_data", 32'(rom_data), 32'h88);
    rom_addr = 18'h00101;
    step();
    check("r100_hit_ok", 32'(rom_ok), 1);
    check("r100_hit_data", 32'(rom_data), 32'h33);
    check("r100_no_req", 32'(sdram_req), 0);
    rom_addr = 18'h00003;
    step();
    check("r000_evicted_req", 32'(sdram_req), 1);
    check("r000_addr", 32'(sdram_addr), 32'h0);
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'hDDCCBBAA;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    step();
    check("r000_ok", 32'(rom_ok), 1);
    check("r000_data", 32'(rom_data), 32'hDD);

    // abort attempt: cs drops during WAIT, fill still cached
    rom_addr = 18'h00300;
    step();
    check("abort_req", 32'(sdram_req), 1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; rom_cs = 1'b0; rom_addr = 18'h00005;
    step();
    data_rdy = 1'b1; data_read = 32'hA0B0C0D0;
    step();
    data_rdy = 1'b0;
    step();
    check("abort_idle_ok", 32'(rom_ok), 0);
    check("abort_idle_req", 32'(sdram_req), 0);
    rom_cs = 1'b1; rom_addr = 18'h00302;
    step();
    check("abort_cached_ok", 32'(rom_ok), 1);
    check("abort_cached_data", 32'(rom_data), 32'hB0);
    check("abort_cached_noreq", 32'(sdram_req), 0);

    // flush on the data_rdy cycle
    rom_addr = 18'h00400;
    step();
    check("flush_req", 32'(sdram_req), 1);
    check("flush_req_addr", 32'(sdram_addr), 32'h400);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b1; data_read = 32'h12345678; flush = 1'b1;
    step();
    data_rdy = 1'b0; flush = 1'b0;
    check("flush_no_ok", 32'(rom_ok), 0);
    step();
    check("flush_rereq", 32'(sdram_req), 1);
    check("flush_rereq_addr", 32'(sdram_addr), 32'h400);

    // reset mid-REQ, then a stray data_rdy
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(sdram_req), 0);
    check("arst_ok", 32'(rom_ok), 0);
    check("arst_addr", 32'(sdram_addr), 0);
    step();
    rst_n = 1'b1; rom_cs = 1'b0; data_rdy = 1'b1; data_read = 32'hCAFEF00D;
    step();
    data_rdy = 1'b0;
    check("stray_no_req", 32'(sdram_req), 0);
    step();
    rom_cs = 1'b1; rom_addr = 18'h00400;
    step();
    check("stray_no_ok", 32'(rom_ok), 0);
    check("stray_miss_req", 32'(sdram_req), 1);
    rom_addr = 18'h00302;
    step();
    check("post_rst_still_req", 32'(sdram_req), 1);
    check("post_rst_no_ok", 32'(rom_ok), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
